// File: rtl/legv8_pkg.sv
// Shared LEGv8 datapath definitions: sequencer states, PC step constants and
// sign-extension control encodings used across the fetch/decode stages.
package legv8_pkg;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    REQ  = 2'd1,
    EXEC = 2'd2,
    HALT = 2'd3
  } seq_state_t;

  localparam int PC_INCR  = 4;
  localparam int BR_SHIFT = 2;

  // Kept here so the sign-extension stage and decode agree on the encoding
  typedef enum logic [2:0] {
    SE_I    = 3'd0,
    SE_D    = 3'd1,
    SE_B    = 3'd2,
    SE_CBZ  = 3'd3,
    SE_MOVZ = 3'd4
  } signext_ctl_t;

endpackage

// File: rtl/next_pc_calc.sv
// Combinational next-PC selection: sequential step or word-scaled branch offset.
module next_pc_calc
  import legv8_pkg::*;
#(
  parameter int PC_W = 64
) (
  input  logic [PC_W-1:0]        CurrentPC,
  input  logic signed [PC_W-1:0] BusImm,
  input  logic                   Branch,
  input  logic                   Uncondbranch,
  input  logic                   ALUZero,
  output logic [PC_W-1:0]        NextPC,
  output logic                   Taken
);

  logic signed [PC_W-1:0] imm_scaled;

  // The top BR_SHIFT bits of the immediate fall off; arithmetic wraps silently
  assign imm_scaled = BusImm <<< BR_SHIFT;
  assign Taken      = Uncondbranch | (Branch & ALUZero);
  assign NextPC     = CurrentPC + (Taken ? $unsigned(imm_scaled) : PC_W'(PC_INCR));

endmodule

// File: rtl/pc_fetch_sequencer.sv
// Program counter and instruction fetch sequencer (BOOT/REQ/EXEC/HALT).
// Optional performance counters are built when PC_PERF_COUNTERS_EN is defined.
module pc_fetch_sequencer
  import legv8_pkg::*;
#(
  parameter int              PC_W     = 64,
  parameter logic [PC_W-1:0] RESET_PC = {PC_W{1'b0}}
) (
  input  logic            CLK,
  input  logic            Reset,
  output logic            IMemReq,
  output logic [PC_W-1:0] IMemAddr,
  input  logic            IMemAck,
  input  logic [31:0]     IMemData,
  output logic [31:0]     Instruction,
  output logic            InstrValid,
  output logic [PC_W-1:0] CurrentPC,
  input  logic [PC_W-1:0] BusImm,
  input  logic            Branch,
  input  logic            Uncondbranch,
  input  logic            ALUZero,
  input  logic            Halt,
  output logic            Halted,
  output logic [31:0]     RetireCount,
  output logic [31:0]     TakenCount
);

  seq_state_t      state;
  logic [PC_W-1:0] next_pc;
  logic            taken;

  next_pc_calc #(.PC_W(PC_W)) u_next_pc (
    .CurrentPC    (CurrentPC),
    .BusImm       (BusImm),
    .Branch       (Branch),
    .Uncondbranch (Uncondbranch),
    .ALUZero      (ALUZero),
    .NextPC       (next_pc),
    .Taken        (taken)
  );

  assign IMemAddr = CurrentPC;

  // Outputs are registered from the next state so they line up with it exactly
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state       <= BOOT;
      CurrentPC   <= RESET_PC;
      Instruction <= '0;
      InstrValid  <= 1'b0;
      IMemReq     <= 1'b0;
      Halted      <= 1'b0;
    end else begin
      case (state)
        BOOT: begin
          state   <= REQ;
          IMemReq <= 1'b1;
        end
        REQ: begin
          if (IMemAck) begin
            Instruction <= IMemData;
            state       <= EXEC;
            IMemReq     <= 1'b0;
            InstrValid  <= 1'b1;
          end
        end
        EXEC: begin
          CurrentPC  <= next_pc;
          InstrValid <= 1'b0;
          if (Halt) begin
            state  <= HALT;
            Halted <= 1'b1;
          end else begin
            state   <= REQ;
            IMemReq <= 1'b1;
          end
        end
        HALT: begin
          state <= HALT;
        end
        default: begin
          state <= BOOT;
        end
      endcase
    end
  end

`ifdef PC_PERF_COUNTERS_EN
  logic [31:0] retire_cnt;
  logic [31:0] taken_cnt;

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      retire_cnt <= '0;
      taken_cnt  <= '0;
    end else if (state == EXEC) begin
      retire_cnt <= retire_cnt + 32'd1;
      if (taken) begin
        taken_cnt <= taken_cnt + 32'd1;
      end
    end
  end

  assign RetireCount = retire_cnt;
  assign TakenCount  = taken_cnt;
`else
  logic unused_taken;

  assign unused_taken = taken;
  assign RetireCount  = '0;
  assign TakenCount   = '0;
`endif

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Scoreboard bench for pc_fetch_sequencer: directed instruction vectors with
// hand-computed PCs; a negedge monitor pops expected fetches and executes.
module tb_pc_fetch_sequencer;

  localparam logic [63:0] RST_PC = 64'h100;

  logic        CLK = 1'b0;
  logic        Reset;
  logic        IMemReq;
  logic [63:0] IMemAddr;
  logic        IMemAck;
  logic [31:0] IMemData;
  logic [31:0] Instruction;
  logic        InstrValid;
  logic [63:0] CurrentPC;
  logic [63:0] BusImm;
  logic        Branch;
  logic        Uncondbranch;
  logic        ALUZero;
  logic        Halt;
  logic        Halted;
  logic [31:0] RetireCount;
  logic [31:0] TakenCount;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] word;
  } exp_t;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] word;
    int          dly;
    logic        unc;
    logic        br;
    logic        zero;
    logic [63:0] imm;
    logic        halt;
  } vec_t;

  exp_t        exec_q[$];
  logic [63:0] fetch_q[$];
  vec_t        vecs[14];

  pc_fetch_sequencer #(.PC_W(64), .RESET_PC(RST_PC)) dut (
    .CLK          (CLK),
    .Reset        (Reset),
    .IMemReq      (IMemReq),
    .IMemAddr     (IMemAddr),
    .IMemAck      (IMemAck),
    .IMemData     (IMemData),
    .Instruction  (Instruction),
    .InstrValid   (InstrValid),
    .CurrentPC    (CurrentPC),
    .BusImm       (BusImm),
    .Branch       (Branch),
    .Uncondbranch (Uncondbranch),
    .ALUZero      (ALUZero),
    .Halt         (Halt),
    .Halted       (Halted),
    .RetireCount  (RetireCount),
    .TakenCount   (TakenCount)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: compare whatever the DUT presents against the queued expectations
  always @(negedge CLK) begin
    if (Reset === 1'b0) begin
      if (IMemReq && IMemAck) begin
        if (fetch_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL fetch_unexpected: got addr %h expected no fetch", IMemAddr);
        end else begin
          chk("fetch_addr", IMemAddr, fetch_q.pop_front());
        end
      end
      if (InstrValid) begin
        if (exec_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL exec_unexpected: got pc %h expected no InstrValid", CurrentPC);
        end else begin
          exp_t e;
          e = exec_q.pop_front();
          chk("exec_pc", CurrentPC, e.pc);
          chk("exec_instr", {32'h0, Instruction}, {32'h0, e.word});
        end
      end
    end
  end

  // Values driven outside EXEC; the DUT must ignore them
  task automatic drive_noise();
    BusImm       = 64'h0000_0000_0000_0123;
    Branch       = 1'b1;
    Uncondbranch = 1'b1;
    ALUZero      = 1'b1;
    Halt         = 1'b1;
  endtask

  task automatic run_vec(input vec_t v);
    int n;
    n = 0;
    while (IMemReq !== 1'b1 && n < 50) begin
      @(posedge CLK); #1;
      n++;
    end
    if (IMemReq !== 1'b1) begin
      $display("FAIL req_timeout: got IMemReq=%b expected 1 within 50 cycles", IMemReq);
      $fatal(1, "request timeout");
    end
    repeat (v.dly) begin
      @(posedge CLK); #1;
    end
    fetch_q.push_back(v.pc);
    exec_q.push_back('{pc: v.pc, word: v.word});
    IMemAck  = 1'b1;
    IMemData = v.word;
    @(posedge CLK); #1;
    // EXEC cycle: real controls, plus a stray ack that must be ignored
    IMemData     = 32'hDEAD_BEEF;
    BusImm       = v.imm;
    Branch       = v.br;
    Uncondbranch = v.unc;
    ALUZero      = v.zero;
    Halt         = v.halt;
    @(posedge CLK); #1;
    IMemAck = 1'b0;
    drive_noise();
  endtask

  initial begin
    vecs[0]  = '{64'h100, 32'h9100_0421, 0, 1'b0, 1'b0, 1'b0, 64'h0, 1'b0};
    vecs[1]  = '{64'h104, 32'h8B02_0020, 3, 1'b0, 1'b0, 1'b0, 64'h0, 1'b0};
    vecs[2]  = '{64'h108, 32'hF840_0041, 1, 1'b0, 1'b0, 1'b0, 64'h0, 1'b0};
    vecs[3]  = '{64'h10C, 32'h1400_003D, 0, 1'b1, 1'b0, 1'b0, 64'h3D, 1'b0};
    vecs[4]  = '{64'h200, 32'hB400_00A1, 2, 1'b0, 1'b1, 1'b0, 64'h5, 1'b0};
    vecs[5]  = '{64'h204, 32'h17FF_FFFF, 0, 1'b1, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0};
    vecs[6]  = '{64'h200, 32'h17FF_FFFE, 1, 1'b1, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0};
    vecs[7]  = '{64'h1F8, 32'hAA03_0041, 2, 1'b0, 1'b0, 1'b0, 64'h0, 1'b0};
    vecs[8]  = '{64'h1FC, 32'hCB02_0020, 0, 1'b0, 1'b0, 1'b1, 64'h7777, 1'b0};
    vecs[9]  = '{64'h200, 32'hB400_00A2, 1, 1'b0, 1'b1, 1'b1, 64'h5, 1'b0};
    vecs[10] = '{64'h214, 32'h17FF_FF7A, 0, 1'b1, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FF7A, 1'b0};
    vecs[11] = '{64'hFFFF_FFFF_FFFF_FFFC, 32'h9100_0842, 1, 1'b0, 1'b0, 1'b0, 64'h0, 1'b0};
    vecs[12] = '{64'h0, 32'h1400_00C0, 0, 1'b1, 1'b0, 1'b0, 64'hC000_0000_0000_00C0, 1'b0};
    vecs[13] = '{64'h300, 32'hD440_0000, 2, 1'b0, 1'b0, 1'b0, 64'h0, 1'b1};

    Reset    = 1'b1;
    IMemAck  = 1'b0;
    IMemData = 32'h0;
    drive_noise();
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_pc", CurrentPC, RST_PC);
    chk("rst_instr", {32'h0, Instruction}, 64'h0);
    chk("rst_valid", {63'h0, InstrValid}, 64'h0);
    chk("rst_req", {63'h0, IMemReq}, 64'h0);
    chk("rst_halted", {63'h0, Halted}, 64'h0);
    chk("rst_retire", {32'h0, RetireCount}, 64'h0);
    chk("rst_taken", {32'h0, TakenCount}, 64'h0);
    Reset = 1'b0;
    @(posedge CLK); #1;
    chk("boot_req", {63'h0, IMemReq}, 64'h1);

    for (int i = 0; i < 14; i++) begin
      run_vec(vecs[i]);
      if (i == 9) begin
`ifdef PC_PERF_COUNTERS_EN
        chk("retire_10", {32'h0, RetireCount}, 64'd10);
        chk("taken_10", {32'h0, TakenCount}, 64'd4);
`else
        chk("retire_off", {32'h0, RetireCount}, 64'd0);
        chk("taken_off", {32'h0, TakenCount}, 64'd0);
`endif
      end
    end

    // Halt taken at 0x300: PC still advances, then nothing more is fetched
    chk("halt_pc", CurrentPC, 64'h304);
    chk("halt_flag", {63'h0, Halted}, 64'h1);
    IMemAck = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge CLK); #1;
      chk("halt_noreq", {63'h0, IMemReq}, 64'h0);
      chk("halt_novalid", {63'h0, InstrValid}, 64'h0);
      chk("halt_pc_hold", CurrentPC, 64'h304);
    end
    IMemAck = 1'b0;

    // Reset out of HALT, then reset again in REQ as the ack arrives
    Reset = 1'b1;
    @(posedge CLK); #1;
    Reset = 1'b0;
    @(posedge CLK); #1;
    chk("reboot_req", {63'h0, IMemReq}, 64'h1);
    @(posedge CLK); #1;
    IMemAck  = 1'b1;
    IMemData = 32'hCAFE_F00D;
    Reset    = 1'b1;
    #1;
    chk("midrst_req", {63'h0, IMemReq}, 64'h0);
    @(posedge CLK); #1;
    chk("midrst_instr", {32'h0, Instruction}, 64'h0);
    chk("midrst_pc", CurrentPC, RST_PC);
    chk("midrst_halted", {63'h0, Halted}, 64'h0);
    chk("midrst_retire", {32'h0, RetireCount}, 64'h0);
    IMemAck = 1'b0;
    Reset   = 1'b0;

    run_vec('{64'h100, 32'h9100_0C63, 1, 1'b0, 1'b0, 1'b0, 64'h0, 1'b0});
    chk("post_rst_pc", CurrentPC, 64'h104);
`ifdef PC_PERF_COUNTERS_EN
    chk("post_rst_retire", {32'h0, RetireCount}, 64'd1);
`else
    chk("post_rst_retire", {32'h0, RetireCount}, 64'd0);
`endif

    repeat (2) @(posedge CLK);
    chk("exec_q_drained", 64'(exec_q.size()), 64'd0);
    chk("fetch_q_drained", 64'(fetch_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
